iq_sample_source: RTL

Sample source stage directly upstream of the IQ quadratic interpolator. On a start command it reads a configurable window of samples from a synchronous-read signal memory and pushes them, one per cycle, into the interpolator's input FIFOs. It stalls whenever the downstream almost-full flag is raised and reports progress through a status word. One instance drives the I and Q inputs in lock-step, because both FIFOs receive the same write strobe.

---
 rtl/iq_sample_source.sv | 137 +++++++++++++
 1 files changed

// File: rtl/iq_sample_source.sv
// iq_sample_source: streams a window of signal-memory samples into the
// I/Q interpolator FIFOs, one per cycle, stalling on downstream almost-full.
//
// Ports:
//   clk, rstn     clock, async active-low reset
//   start_i       one-cycle start pulse (sampled in IDLE only)
//   stop_i        one-cycle stop request (loop-mode STREAM only)
//   Afull_i       downstream almost-full, blocks new reads
//   config_reg    [7:0] depth, [15:8] offset, [17:16] mode
//   mem_data_i    memory read data, one cycle after addr_Mem_o
//   addr_Mem_o    memory read address
//   WE_fifo_o     FIFO write strobe (shared by I and Q)
//   data_o        FIFO write data
//   status_reg    [0] busy, [1] done, [2] stalled, [15:8] write count
//   done_o        one-cycle completion pulse
module iq_sample_source #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE_M = 7
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  Afull_i,
  input  logic [17:0]           config_reg,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic [MEM_SIZE_M-1:0] addr_Mem_o,
  output logic                  WE_fifo_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [15:0]           status_reg,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t                state;
  logic [7:0]            depth_q;
  logic [MEM_SIZE_M-1:0] off_q;
  logic                  loop_q;
  logic [7:0]            rd_idx;
  logic                  rd_valid;
  logic [7:0]            count;
  logic                  done_flag;

  logic                  issue;
  logic                  last;
  logic [7:0]            idx_next;
  logic [MEM_SIZE_M-1:0] addr_next;
  logic                  busy;
  logic                  stalled;

  assign issue = (state == STREAM) && !Afull_i;
  assign last  = (rd_idx == depth_q - 8'd1);

  // Loop mode needs the wrap; in one-shot the last read leaves STREAM,
  // so the wrapped index is never used there.
  assign idx_next  = last ? 8'd0 : rd_idx + 8'd1;
  assign addr_next = off_q + MEM_SIZE_M'(idx_next);

  assign busy    = (state != IDLE);
  assign stalled = (state == STREAM) && Afull_i;

  // Memory has one cycle of read latency, so the strobe is just the
  // delayed issue and data passes straight through from the memory.
  assign WE_fifo_o  = rd_valid;
  assign data_o     = rd_valid ? mem_data_i : '0;
  assign status_reg = {count, 5'b0, stalled, done_flag, busy};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      depth_q    <= '0;
      off_q      <= '0;
      loop_q     <= 1'b0;
      rd_idx     <= '0;
      rd_valid   <= 1'b0;
      count      <= '0;
      done_flag  <= 1'b0;
      addr_Mem_o <= '0;
      done_o     <= 1'b0;
    end else begin
      rd_valid <= issue;
      done_o   <= 1'b0;
      if (rd_valid) begin
        count <= count + 8'd1;
      end
      unique case (state)
        IDLE: begin
          if (start_i) begin
            depth_q    <= config_reg[7:0];
            off_q      <= MEM_SIZE_M'(config_reg[15:8]);
            loop_q     <= (config_reg[17:16] == 2'b01);
            rd_idx     <= '0;
            addr_Mem_o <= MEM_SIZE_M'(config_reg[15:8]);
            count      <= '0;
            done_flag  <= 1'b0;
            if (config_reg[7:0] == 8'd0) begin
              state     <= DONE;
              done_o    <= 1'b1;
              done_flag <= 1'b1;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (issue) begin
            rd_idx     <= idx_next;
            addr_Mem_o <= addr_next;
          end
          // A stop that lands on an issued read still lets that read
          // land in DRAIN's cycle as the final write.
          if (loop_q ? stop_i : (issue && last)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          state     <= DONE;
          done_o    <= 1'b1;
          done_flag <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
